// File: rtl/fifo_rd_stream_if.sv
// FIFO read port plus the outgoing sample stream, bundled for fifo_rd_stream.
// The drain controller is the master; the FIFO/consumer side is the slave.
interface fifo_rd_stream_if #(
  parameter int DATA_WIDTH = 31,
  parameter int FCNT_WIDTH = 16
);
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  rd_empty;
  logic                  m_valid;
  logic                  m_ready;
  logic [DATA_WIDTH-1:0] m_data;
  logic                  m_last;
  logic [FCNT_WIDTH-1:0] sample_idx;
  logic [FCNT_WIDTH-1:0] frame_idx;

  modport master (
    output rd_en,
    input  rd_data,
    input  rd_empty,
    output m_valid,
    input  m_ready,
    output m_data,
    output m_last,
    output sample_idx,
    output frame_idx
  );

  modport slave (
    input  rd_en,
    output rd_data,
    output rd_empty,
    input  m_valid,
    output m_ready,
    input  m_data,
    input  m_last,
    input  sample_idx,
    input  frame_idx
  );
endinterface

// File: rtl/fifo_rd_stream.sv
// Read-side drain controller: pops the sample FIFO into a small credit-managed
// buffer and presents it as a valid/ready stream with frame position tags.
module fifo_rd_stream #(
  parameter int DATA_WIDTH = 31,
  parameter int RD_LATENCY = 1,
  parameter int FRAME_LEN  = 1024,
  parameter int FCNT_WIDTH = 16
) (
  input  logic             rd_clk,
  input  logic             rd_rst_n,
  input  logic             en,
  input  logic             frame_clr,
  output logic             busy,
  fifo_rd_stream_if.master bus
);

  localparam int BUF_DEPTH = RD_LATENCY + 2;
  localparam int PTR_W     = $clog2(BUF_DEPTH);
  localparam int CNT_W     = $clog2(BUF_DEPTH + 1);

  localparam logic [FCNT_WIDTH-1:0] LAST_IDX = FCNT_WIDTH'(FRAME_LEN - 1);
  localparam logic [PTR_W-1:0]      PTR_MAX  = PTR_W'(BUF_DEPTH - 1);
  localparam logic [CNT_W:0]        CREDIT   = (CNT_W + 1)'(BUF_DEPTH);

  logic                  run_q;
  logic [RD_LATENCY-1:0] pipe_q, pipe_d;
  logic [DATA_WIDTH-1:0] mem_q [BUF_DEPTH];
  logic [PTR_W-1:0]      wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]      rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]      occ_q, occ_d;
  logic [FCNT_WIDTH-1:0] sample_q, sample_d;
  logic [FCNT_WIDTH-1:0] frame_q, frame_d;

  logic [CNT_W-1:0]      inflight;
  logic [CNT_W:0]        pending;
  logic                  issue;
  logic                  land;
  logic                  pop;
  logic                  at_last;

  function automatic logic [PTR_W-1:0] ptrInc(input logic [PTR_W-1:0] p);
    return (p == PTR_MAX) ? '0 : p + 1'b1;
  endfunction

  always_comb begin
    inflight = '0;
    for (int i = 0; i < RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(pipe_q[i]);
    end
  end

  // Credits count landed and still-in-flight words, never the same-cycle pop,
  // so rd_en stays free of any path from m_ready and a landing always has room.
  assign pending = {1'b0, occ_q} + {1'b0, inflight};
  assign issue   = run_q & en & ~bus.rd_empty & (pending < CREDIT);
  assign land    = pipe_q[RD_LATENCY-1];
  assign pop     = (occ_q != '0) & bus.m_ready;
  assign at_last = (sample_q == LAST_IDX);

  always_comb begin
    pipe_d   = RD_LATENCY'({pipe_q, issue});
    wr_ptr_d = land ? ptrInc(wr_ptr_q) : wr_ptr_q;
    rd_ptr_d = pop  ? ptrInc(rd_ptr_q) : rd_ptr_q;
    occ_d    = occ_q + CNT_W'(land) - CNT_W'(pop);
  end

  always_comb begin
    sample_d = sample_q;
    frame_d  = frame_q;
    if (frame_clr) begin
      sample_d = '0;
      frame_d  = '0;
    end else if (pop) begin
      if (at_last) begin
        sample_d = '0;
        frame_d  = frame_q + 1'b1;
      end else begin
        sample_d = sample_q + 1'b1;
      end
    end
  end

  // run_q holds off the first pop until one edge after reset release.
  always_ff @(posedge rd_clk or negedge rd_rst_n) begin
    if (!rd_rst_n) begin
      run_q    <= 1'b0;
      pipe_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      occ_q    <= '0;
      sample_q <= '0;
      frame_q  <= '0;
      for (int i = 0; i < BUF_DEPTH; i++) begin
        mem_q[i] <= '0;
      end
    end else begin
      run_q    <= 1'b1;
      pipe_q   <= pipe_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      occ_q    <= occ_d;
      sample_q <= sample_d;
      frame_q  <= frame_d;
      if (land) begin
        mem_q[wr_ptr_q] <= bus.rd_data;
      end
    end
  end

  assign bus.rd_en      = issue;
  assign bus.m_valid    = (occ_q != '0);
  assign bus.m_data     = mem_q[rd_ptr_q];
  assign bus.m_last     = (occ_q != '0) & at_last;
  assign bus.sample_idx = sample_q;
  assign bus.frame_idx  = frame_q;
  assign busy           = (pending != '0);

  a_no_empty_read: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(bus.rd_en && bus.rd_empty));
  a_no_overflow: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    !(land && occ_q == CNT_W'(BUF_DEPTH)));
  a_credit_bound: assert property (@(posedge rd_clk) disable iff (!rd_rst_n)
    pending <= CREDIT);

endmodule

// File: tb/tb_fifo_rd_stream.sv
// Directed bench for fifo_rd_stream: a latency-1 instance with 4-sample frames
// and a latency-2 instance fed from a randomly stalling source.
module tb_fifo_rd_stream;

  localparam int DW = 31;
  localparam int FW = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst1_n, rst2_n, en1, en2, clr1, clr2, busy1, busy2;

  fifo_rd_stream_if #(.DATA_WIDTH(DW), .FCNT_WIDTH(FW)) if1();
  fifo_rd_stream_if #(.DATA_WIDTH(DW), .FCNT_WIDTH(FW)) if2();

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(1), .FRAME_LEN(4), .FCNT_WIDTH(FW)) dut1 (
    .rd_clk(clk), .rd_rst_n(rst1_n), .en(en1), .frame_clr(clr1), .busy(busy1), .bus(if1.master));

  fifo_rd_stream #(.DATA_WIDTH(DW), .RD_LATENCY(2), .FRAME_LEN(1024), .FCNT_WIDTH(FW)) dut2 (
    .rd_clk(clk), .rd_rst_n(rst2_n), .en(en2), .frame_clr(clr2), .busy(busy2), .bus(if2.master));

  // FIFO model for dut1: preloaded array, one-cycle read latency.
  logic [DW-1:0] fifoMem1 [0:255];
  int            head1 = 0;
  int            tail1 = 0;
  int            rdEnCount1 = 0;
  logic          fifoClr1 = 1'b0;
  logic [DW-1:0] rdData1Q = '0;

  assign if1.rd_empty = (head1 == tail1);
  assign if1.rd_data  = rdData1Q;

  always @(posedge clk) begin
    if (fifoClr1) begin
      head1      <= 0;
      rdEnCount1 <= 0;
    end else if (if1.rd_en) begin
      rdData1Q   <= fifoMem1[head1[7:0]];
      head1      <= head1 + 1;
      rdEnCount1 <= rdEnCount1 + 1;
    end
  end

  // FIFO model for dut2: endless counting source behind an output register.
  logic          fEmpty2 = 1'b1;
  logic [DW-1:0] src2 = '0;
  logic [DW-1:0] st2a = '0;
  logic [DW-1:0] st2b = '0;
  int            issues2 = 0;

  assign if2.rd_empty = fEmpty2;
  assign if2.rd_data  = st2b;

  always @(posedge clk) begin
    st2b <= st2a;
    if (if2.rd_en) begin
      st2a    <= src2;
      src2    <= src2 + 1'b1;
      issues2 <= issues2 + 1;
    end
  end

  typedef struct {
    logic          en;
    logic          mReady;
    logic          expRdEn;
    logic          expValid;
    logic          chkData;
    logic [DW-1:0] expData;
    logic          expLast;
    logic [FW-1:0] expSample;
    logic [FW-1:0] expFrame;
    logic          expBusy;
  } vec_t;

  vec_t          vecs [15];
  int            vecCount = 0;
  int            missCount = 0;
  logic          mon1On = 1'b0;
  logic [DW-1:0] exp1 = '0;
  int            pops1 = 0;
  logic [DW-1:0] exp2 = '0;
  int            pops2 = 0;

  function automatic vec_t mkVec(input logic e, input logic r, input logic rdEn, input logic v,
                                 input logic chk, input int d, input logic last, input int s,
                                 input int f, input logic b);
    vec_t x;
    x.en = e; x.mReady = r; x.expRdEn = rdEn; x.expValid = v; x.chkData = chk;
    x.expData = DW'(d); x.expLast = last; x.expSample = FW'(s); x.expFrame = FW'(f);
    x.expBusy = b;
    return x;
  endfunction

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    vecCount++;
    if (act !== exp) begin
      missCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input vec_t v);
    en1 = v.en;
    if1.m_ready = v.mReady;
  endtask

  task automatic sampleCycle();
    @(negedge clk);
    if (mon1On && if1.m_valid && if1.m_ready) begin
      checkOutput("stream1 order", 64'(if1.m_data), 64'(exp1));
      exp1 = exp1 + 1'b1;
      pops1++;
    end
  endtask

  task automatic advance();
    @(posedge clk);
    #1;
  endtask

  task automatic resetDut1();
    rst1_n = 1'b0;
    en1 = 1'b0;
    clr1 = 1'b0;
    if1.m_ready = 1'b0;
    mon1On = 1'b0;
    fifoClr1 = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    fifoClr1 = 1'b0;
    tail1 = 0;
  endtask

  task automatic loadFifo1(input int base, input int n);
    for (int i = 0; i < n; i++) begin
      fifoMem1[tail1[7:0]] = DW'(base + i);
      tail1++;
    end
  endtask

  initial begin
    rst1_n = 1'b0; rst2_n = 1'b0;
    en1 = 1'b0; en2 = 1'b0; clr1 = 1'b0; clr2 = 1'b0;
    if1.m_ready = 1'b0; if2.m_ready = 1'b0;

    // Cycle-by-cycle table: words 0..9, full throughput, frames of 4.
    //               en rdy rdEn vld chk data last smp frm busy
    vecs[0]  = mkVec(1, 1,  0,   0,  0,  0,   0,   0,  0,  0);
    vecs[1]  = mkVec(1, 1,  1,   0,  0,  0,   0,   0,  0,  0);
    vecs[2]  = mkVec(1, 1,  1,   0,  0,  0,   0,   0,  0,  1);
    vecs[3]  = mkVec(1, 1,  1,   1,  1,  0,   0,   0,  0,  1);
    vecs[4]  = mkVec(1, 1,  1,   1,  1,  1,   0,   1,  0,  1);
    vecs[5]  = mkVec(1, 1,  1,   1,  1,  2,   0,   2,  0,  1);
    vecs[6]  = mkVec(1, 1,  1,   1,  1,  3,   1,   3,  0,  1);
    vecs[7]  = mkVec(1, 1,  1,   1,  1,  4,   0,   0,  1,  1);
    vecs[8]  = mkVec(1, 1,  1,   1,  1,  5,   0,   1,  1,  1);
    vecs[9]  = mkVec(1, 1,  1,   1,  1,  6,   0,   2,  1,  1);
    vecs[10] = mkVec(1, 1,  1,   1,  1,  7,   1,   3,  1,  1);
    vecs[11] = mkVec(1, 1,  0,   1,  1,  8,   0,   0,  2,  1);
    vecs[12] = mkVec(1, 1,  0,   1,  1,  9,   0,   1,  2,  1);
    vecs[13] = mkVec(1, 1,  0,   0,  0,  0,   0,   2,  2,  0);
    vecs[14] = mkVec(1, 1,  0,   0,  0,  0,   0,   2,  2,  0);

    resetDut1();
    @(negedge clk);
    checkOutput("reset state", {if1.rd_en, if1.m_valid, if1.m_last, busy1, if1.sample_idx,
                if1.frame_idx, if1.m_data}, 64'd0);
    advance();

    loadFifo1(0, 10);
    rst1_n = 1'b1;
    for (int k = 0; k < 15; k++) begin
      applyStimulus(vecs[k]);
      @(negedge clk);
      checkOutput($sformatf("t1 row%0d ctrl", k),
                  64'({if1.rd_en, if1.m_valid, if1.m_last, busy1, if1.sample_idx, if1.frame_idx}),
                  64'({vecs[k].expRdEn, vecs[k].expValid, vecs[k].expLast, vecs[k].expBusy,
                       vecs[k].expSample, vecs[k].expFrame}));
      if (vecs[k].chkData)
        checkOutput($sformatf("t1 row%0d data", k), 64'(if1.m_data), 64'(vecs[k].expData));
      advance();
    end
    checkOutput("t1 rd_en count", 64'(rdEnCount1), 64'd10);

    // Backpressure: stall 8 cycles once the stream is flowing.
    resetDut1();
    loadFifo1(100, 20);
    exp1 = DW'(100); pops1 = 0; mon1On = 1'b1;
    rst1_n = 1'b1; en1 = 1'b1; if1.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin sampleCycle(); advance(); end
    if1.m_ready = 1'b0;
    for (int c = 6; c < 14; c++) begin
      sampleCycle();
      if (c >= 7) checkOutput($sformatf("t2 stall rd_en c%0d", c), 64'(if1.rd_en), 64'd0);
      checkOutput($sformatf("t2 held c%0d", c), 64'({if1.m_valid, if1.m_data}), {32'd0, 1'b1, 31'd103});
      advance();
    end
    if1.m_ready = 1'b1;
    for (int g = 0; g < 60 && pops1 < 20; g++) begin sampleCycle(); advance(); end
    checkOutput("t2 words delivered", 64'(pops1), 64'd20);
    checkOutput("t2 busy after", 64'(busy1), 64'd0);

    // en dropped with two words in flight/buffered, then resumed.
    resetDut1();
    loadFifo1(200, 40);
    exp1 = DW'(200); pops1 = 0; mon1On = 1'b1;
    rst1_n = 1'b1; en1 = 1'b1; if1.m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin sampleCycle(); advance(); end
    en1 = 1'b0;
    for (int c = 5; c < 10; c++) begin
      sampleCycle();
      checkOutput($sformatf("t4 rd_en off c%0d", c), 64'(if1.rd_en), 64'd0);
      if (c >= 7) checkOutput($sformatf("t4 idle c%0d", c), 64'({busy1, if1.m_valid}), 64'd0);
      advance();
    end
    checkOutput("t4 drained words", 64'(pops1), 64'd4);
    en1 = 1'b1;
    for (int g = 0; g < 40 && pops1 < 12; g++) begin sampleCycle(); advance(); end
    checkOutput("t4 resumed words", 64'(pops1), 64'd12);

    // frame_clr in the same cycle as the last-word pop.
    resetDut1();
    loadFifo1(0, 10);
    rst1_n = 1'b1; en1 = 1'b1; if1.m_ready = 1'b1;
    for (int c = 0; c < 6; c++) begin sampleCycle(); advance(); end
    clr1 = 1'b1;
    @(negedge clk);
    checkOutput("t7 last before clr", 64'({if1.m_valid, if1.m_last, if1.sample_idx}), {46'd0, 1'b1, 1'b1, 16'd3});
    advance();
    clr1 = 1'b0;
    @(negedge clk);
    checkOutput("t7 counters cleared", 64'({if1.sample_idx, if1.frame_idx}), 64'd0);
    checkOutput("t7 data kept", 64'({if1.m_valid, if1.m_data}), {32'd0, 1'b1, 31'd4});
    advance();

    // Asynchronous reset mid-frame with a full buffer.
    resetDut1();
    loadFifo1(0, 20);
    rst1_n = 1'b1; en1 = 1'b1; if1.m_ready = 1'b1;
    for (int c = 0; c < 5; c++) begin sampleCycle(); advance(); end
    if1.m_ready = 1'b0;
    for (int c = 5; c < 9; c++) begin sampleCycle(); advance(); end
    checkOutput("t6 pre-reset", 64'({if1.m_valid, busy1, if1.sample_idx, if1.m_data}), {15'd0, 1'b1, 1'b1, 16'd2, 31'd2});
    #2;
    rst1_n = 1'b0;
    #1;
    checkOutput("t6 async reset", {if1.rd_en, if1.m_valid, if1.m_last, busy1, if1.sample_idx,
                if1.frame_idx, if1.m_data}, 64'd0);
    advance();

    // Latency-2 instance: random empty flag against random m_ready.
    en2 = 1'b1;
    rst2_n = 1'b1;
    for (int c = 0; c < 5000; c++) begin
      fEmpty2 = ($urandom_range(0, 2) == 0);
      if2.m_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
      checkOutput("t5 rd_en with empty", 64'(if2.rd_en & if2.rd_empty), 64'd0);
      checkOutput("t5 occupancy bound", 64'((issues2 - pops2) <= 4), 64'd1);
      if (if2.m_valid && if2.m_ready) begin
        checkOutput("t5 order", 64'(if2.m_data), 64'(exp2));
        exp2 = exp2 + 1'b1;
        pops2++;
      end
      advance();
    end
    fEmpty2 = 1'b1;
    if2.m_ready = 1'b1;
    for (int c = 0; c < 12; c++) begin
      @(negedge clk);
      if (if2.m_valid && if2.m_ready) begin
        checkOutput("t5 drain order", 64'(if2.m_data), 64'(exp2));
        exp2 = exp2 + 1'b1;
        pops2++;
      end
      advance();
    end
    checkOutput("t5 all delivered", 64'(issues2 - pops2), 64'd0);
    checkOutput("t5 busy after", 64'(busy2), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecCount, missCount);
    $finish;
  end

endmodule

// File: doc/fifo_rd_stream.md
Name: fifo_rd_stream

Overview:
- Read-side drain controller for the 31-bit, 256-deep async sample FIFO in the audio FFT/FIR path.
- Sits in the read clock domain. It pops words via rd_en/rd_data/rd_empty, absorbs the FIFO read latency in a small credit-managed buffer, and presents a valid/ready stream with frame-boundary tagging.
- The downstream consumer is the FFT/FIR input stage.

Parameters:
- DATA_WIDTH, 31, FIFO word width.
- RD_LATENCY, 1, cycles from rd_en high to rd_data valid. Use 1 when the FIFO has no output register, 2 with one. Legal values 1..2.
- FRAME_LEN, 1024, samples per frame. Legal range 2..65536.
- FCNT_WIDTH, 16, width of the frame-sample and frame-index counters.

Ports:
- rd_clk  in  1  read-domain clock; all logic is rising-edge.
- rd_rst_n  in  1  reset, asynchronous assert, active-low.
- en  in  1  when high, allow new FIFO pops; when low, in-flight words still land and drain.
- frame_clr  in  1  synchronous pulse; zeroes sample_idx and frame_idx.
- rd_en  out  1  FIFO read enable.
- rd_data  in  DATA_WIDTH  FIFO read data.
- rd_empty  in  1  FIFO empty flag.
- m_valid  out  1  output word valid.
- m_ready  in  1  downstream accept.
- m_data  out  DATA_WIDTH  output word.
- m_last  out  1  high with the last word of each frame.
- sample_idx  out  FCNT_WIDTH  position of the m_data word within its frame.
- frame_idx  out  FCNT_WIDTH  count of completed frames, modulo 2^FCNT_WIDTH.
- busy  out  1  high while occ+inflight != 0.

Behaviour:
- Reset (rd_rst_n low, async):
  - rd_en=0, m_valid=0, m_data=0, m_last=0, sample_idx=0, frame_idx=0, busy=0.
  - Buffer and latency pipe are emptied.
- Buffer:
  - Circular, BUF_DEPTH = RD_LATENCY+2 entries.
  - occ = words held. inflight = rd_en issues not yet landed, tracked by a RD_LATENCY-stage shift register of rd_en.
- Issue rule:
  - rd_en = en & ~rd_empty & (occ + inflight < BUF_DEPTH).
  - rd_en has no combinational path from m_ready.
  - rd_en is never high while rd_empty is high.
- Landing: the latency pipe tail high → rd_data is written at wr_ptr that cycle. This write is guaranteed by the credit rule and can never overflow.
- Output:
  - m_valid = (occ != 0).
  - m_data is the head entry and is held stable while m_valid & ~m_ready.
  - A pop happens on m_valid & m_ready.
- Simultaneous events:
  - A land and a pop in the same cycle leave occ unchanged.
  - A word landing into an empty buffer appears on m_valid the next cycle.
  - Issue-to-visible latency is therefore RD_LATENCY+1 cycles.
- Throughput: sustained 1 word/cycle when the FIFO is non-empty, m_ready=1 and en=1.
- Frame counting (advances on pop):
  - m_last = m_valid & (sample_idx == FRAME_LEN-1).
  - On a pop: if sample_idx == FRAME_LEN-1, then sample_idx←0 and frame_idx←frame_idx+1 (wraps). Otherwise sample_idx+1.
- frame_clr:
  - Takes priority over a same-cycle pop increment.
  - Does not flush data.
- en low mid-stream:
  - No new issues.
  - In-flight words land.
  - The buffer drains normally.
  - busy falls when occ = inflight = 0.
- FIFO going empty mid-frame: m_valid drops; frame counters hold and resume with the next word.
- Reset mid-operation: all in-flight and buffered words are discarded. The FIFO is reset separately by the system.

Test Plan:
- RD_LATENCY=1, FIFO preloaded with 0..9, en=1, m_ready=1:
  - First rd_en in cycle 1 after reset release.
  - m_valid first high in cycle 3.
  - 10 consecutive words 0..9 with no gaps.
  - rd_en count = 10.
  - busy=0 afterwards.
- Backpressure, m_ready low for 8 cycles mid-stream:
  - rd_en stops after occ+inflight reaches 3.
  - m_data held constant.
  - No word lost or duplicated after release.
  - Output sequence strictly increments.
- FRAME_LEN=4, 10 words streamed:
  - m_last high on words 3 and 7.
  - frame_idx goes 0→1→2.
  - sample_idx at word 9 = 1.
- en dropped while 2 words are in flight/buffered:
  - Exactly those words are delivered.
  - rd_en stays 0.
  - busy deasserts after the last pop.
  - Re-asserting en resumes the sequence with no gap in the data values.
- rd_empty toggled randomly against random m_ready for 5000 cycles, RD_LATENCY=2:
  - rd_en & rd_empty never both high.
  - Scoreboard in-order match.
  - occ never exceeds 4.
- Async rd_rst_n pulse mid-frame with words buffered:
  - Outputs immediately go to reset values.
  - frame_clr concurrent with a last-word pop gives sample_idx=0 and frame_idx=0.
